// File: rtl/pe_sequencer_pkg.sv
// Shared encodings for the PE sequencer: FSM states, PE bound levels and PE result latency.
package pe_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // bound_level codes understood by the PE; the sequencer passes them through untouched.
  typedef enum logic [2:0] {
    BOUND_L0 = 3'd0,
    BOUND_L1 = 3'd1,
    BOUND_L2 = 3'd2,
    BOUND_L3 = 3'd3,
    BOUND_L4 = 3'd4,
    BOUND_L5 = 3'd5
  } bound_e;

  // Cycles from pe_en of a pixel's final beat to its pe_out_en strobe.
  localparam int PE_LAT = 2;

endpackage

// File: rtl/pe_res_fifo.sv
// Show-ahead synchronous FIFO holding PE results until the consumer accepts them.
module pe_res_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  // NOTE: storage is deliberately not reset; count marks which words are valid and
  // rd_data is forced to zero while empty, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pe_sequencer.sv
// Feeds one 9-tap MAC processing element from a beat stream and buffers its results
// behind a credit-controlled FIFO, since the PE pipeline cannot be stalled.
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int CELL_BIT   = 8,
  parameter int N_CELL     = 9,
  parameter int BIAS_W     = 16,
  parameter int OUT_W      = 8,
  parameter int PIX_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [2:0]                   cfg_step,
  input  logic [2:0]                   cfg_bound,
  input  logic [PIX_W-1:0]             cfg_npix,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [CELL_BIT*N_CELL-1:0]   op_in,
  input  logic [CELL_BIT*N_CELL-1:0]   op_weight,
  input  logic [BIAS_W-1:0]            op_bias,
  output logic [CELL_BIT*N_CELL-1:0]   pe_in,
  output logic [CELL_BIT*N_CELL-1:0]   pe_weight,
  output logic [BIAS_W-1:0]            pe_bias,
  output logic                         pe_en,
  output logic [2:0]                   pe_step,
  output logic [2:0]                   pe_bound,
  input  logic [OUT_W-1:0]             pe_out,
  input  logic                         pe_out_en,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [OUT_W-1:0]             res_data,
  output logic                         res_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err_gap,
  output logic                         err_ovf
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [1:0]       state;
  logic [2:0]       beat;
  logic [PIX_W-1:0] npix_r;
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] res_cnt;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [OUT_W:0]   fifo_rd;
  logic             cfg_fire;
  logic             op_fire;
  logic             beat_first;
  logic             beat_final;
  logic             pix_final;
  logic             credit_ok;
  logic             push;
  logic             ovf;
  logic             res_is_last;

  // Held low while reset is asserted so every output reads zero during reset.
  assign cfg_ready   = reset && (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign beat_first  = (beat == 3'd0);
  assign beat_final  = (beat == pe_step);
  assign pix_final   = (pix == npix_r - PIX_W'(1));
  assign res_is_last = (res_cnt == npix_r - PIX_W'(1));

  // A new pixel may only start if its result is guaranteed a FIFO slot.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);
  assign op_ready  = (state == ST_RUN) && (!beat_first || credit_ok);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign op_fire   = op_valid && op_ready;
  assign push      = pe_out_en && (inflight != '0);
  assign ovf       = pe_out_en && (inflight == '0);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order of statements in the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      beat     <= '0;
      pix      <= '0;
      npix_r   <= '0;
      res_cnt  <= '0;
      inflight <= '0;
      pe_step  <= '0;
      pe_bound <= '0;
      done     <= 1'b0;
      err_gap  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            pe_step  <= cfg_step;
            pe_bound <= cfg_bound;
            npix_r   <= cfg_npix;
            beat     <= '0;
            pix      <= '0;
            res_cnt  <= '0;
            err_gap  <= 1'b0;
            err_ovf  <= 1'b0;
            if (cfg_npix == '0) done  <= 1'b1;
            else                state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!beat_first && !op_valid) err_gap <= 1'b1;
          if (op_fire) begin
            if (beat_final) begin
              beat <= '0;
              if (pix_final) begin
                pix   <= '0;
                state <= ST_DRAIN;
              end else begin
                pix <= pix + PIX_W'(1);
              end
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0)) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the FSM so a same-cycle overflow wins over the clear at cfg accept.
      if (ovf)  err_ovf <= 1'b1;
      if (push) res_cnt <= res_cnt + PIX_W'(1);

      case ({op_fire && beat_first, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Operand registers hold their last beat when nothing is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pe_en     <= 1'b0;
      pe_in     <= '0;
      pe_weight <= '0;
      pe_bias   <= '0;
    end else begin
      pe_en <= op_fire;
      if (op_fire) begin
        pe_in     <= op_in;
        pe_weight <= op_weight;
        pe_bias   <= beat_first ? op_bias : '0;
      end
    end
  end

  pe_res_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({pe_out, res_is_last}),
    .pop     (res_valid && res_ready),
    .rd_data (fifo_rd),
    .count   (fifo_count)
  );

  assign res_valid = (fifo_count != '0);
  assign res_data  = fifo_rd[OUT_W:1];
  assign res_last  = fifo_rd[0];

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a behavioural PE that sums cell 0 plus bias per pixel.
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_step = '0;
  logic [2:0]  cfg_bound = '0;
  logic [15:0] cfg_npix = '0;
  logic        op_valid = 1'b0;
  logic [71:0] op_in = '0;
  logic [71:0] op_weight = '0;
  logic [15:0] op_bias = '0;
  logic        res_ready = 1'b0;
  logic        cfg_ready, op_ready, pe_en, res_valid, res_last, busy, done, err_gap, err_ovf;
  logic [71:0] pe_in, pe_weight;
  logic [15:0] pe_bias;
  logic [2:0]  pe_step, pe_bound;
  logic [7:0]  res_data;
  logic [7:0]  pe_out;
  logic        pe_out_en;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [15:0] bias_log[$];
  logic [8:0]  rx[$];
  logic [15:0] exp_b[$];
  logic [8:0]  exp_q[$];

  always #5 clk = ~clk;

  pe_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_step(cfg_step),
    .cfg_bound(cfg_bound), .cfg_npix(cfg_npix),
    .op_valid(op_valid), .op_ready(op_ready), .op_in(op_in),
    .op_weight(op_weight), .op_bias(op_bias),
    .pe_in(pe_in), .pe_weight(pe_weight), .pe_bias(pe_bias), .pe_en(pe_en),
    .pe_step(pe_step), .pe_bound(pe_bound), .pe_out(pe_out), .pe_out_en(pe_out_en),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done),
    .err_gap(err_gap), .err_ovf(err_ovf)
  );

  // PE model: result = low byte of (bias + cell 0 of every beat), PE_LAT cycles after the final beat.
  logic [7:0]        acc;
  logic [2:0]        mbeat;
  logic [PE_LAT-1:0] vp;
  logic [7:0]        dp [PE_LAT];
  logic              inj = 1'b0;
  logic [7:0]        inj_data = 8'hAA;
  wire  [7:0]        pe_sum = ((mbeat == 3'd0) ? 8'd0 : acc) + pe_in[7:0] + pe_bias[7:0];
  wire               fin = pe_en && (mbeat == pe_step);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      mbeat <= '0;
      vp    <= '0;
      for (int i = 0; i < PE_LAT; i++) dp[i] <= '0;
    end else begin
      vp    <= {vp[PE_LAT-2:0], fin};
      dp[0] <= pe_sum;
      for (int i = 1; i < PE_LAT; i++) dp[i] <= dp[i-1];
      if (pe_en) begin
        if (fin) mbeat <= '0;
        else begin
          acc   <= pe_sum;
          mbeat <= mbeat + 3'd1;
        end
      end
    end
  end

  assign pe_out_en = vp[PE_LAT-1] | inj;
  assign pe_out    = inj ? inj_data : dp[PE_LAT-1];

  always @(negedge clk) begin
    if (reset) begin
      if (pe_en) bias_log.push_back(pe_bias);
      if (res_valid && res_ready) rx.push_back({res_last, res_data});
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    @(posedge clk); #1;
    bias_log.delete(); rx.delete(); exp_b.delete(); exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_cfg(input logic [2:0] st, input logic [2:0] bd, input logic [15:0] np);
    int t = 0;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_step = st; cfg_bound = bd; cfg_npix = np;
    @(negedge clk);
    while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
    check("cfg_ready", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Must be entered just after a rising edge so the handshake edge is not skipped.
  task automatic send_beat(input logic [7:0] x, input logic [15:0] b);
    int t = 0;
    op_valid = 1'b1; op_in = {9{x}}; op_weight = {9{~x}}; op_bias = b;
    @(negedge clk);
    while (!op_ready && t < 300) begin @(negedge clk); t++; end
    check("op_ready", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    for (int t = 0; t < 1000 && done_cnt < exp_cnt; t++) @(negedge clk);
    check("done_cnt", done_cnt, exp_cnt);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_nres"}, rx.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < rx.size()) check($sformatf("%s_res%0d", tag, i), rx[i], exp_q[i]);
  endtask

  task automatic check_bias(input string tag);
    check({tag, "_nbeats"}, bias_log.size(), exp_b.size());
    foreach (exp_b[i])
      if (i < bias_log.size()) check($sformatf("%s_bias%0d", tag, i), bias_log[i], exp_b[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ctl", {cfg_ready, op_ready, pe_en, res_valid, res_last, busy, done, err_gap, err_ovf}, 0);
    check("rst_data", {|pe_in, |pe_weight, pe_bias, pe_step, pe_bound, res_data}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    check("idle_ports", {cfg_ready, op_ready, busy}, 3'b100);

    // Single pixel: result = 5 + 3.
    clear_logs();
    do_cfg(3'd0, 3'd0, 16'd1);
    send_beat(8'd3, 16'd5);
    @(negedge clk); check("t1_pe_en", {pe_en, pe_bias}, {1'b1, 16'd5});
    @(negedge clk); check("t1_pe_en_off", pe_en, 0);
    @(negedge clk); check("t1_res_early", res_valid, 0);
    @(negedge clk); check("t1_res", {res_valid, res_last, res_data}, {1'b1, 1'b1, 8'd8});
    wait_done(1);
    check("t1_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("t1_done_once", done_cnt, 1);
    exp_q.push_back(9'h108);
    check_results("t1");

    // Multi-step: 3 pixels of 3 beats, bias only on beats 0, 3, 6.
    clear_logs();
    do_cfg(3'd2, 3'd3, 16'd3);
    check("t2_cfg", {pe_step, pe_bound}, {3'd2, 3'd3});
    for (int i = 0; i < 9; i++) send_beat(8'(i + 1), 16'(16 + i));
    wait_done(1);
    for (int i = 0; i < 9; i++) exp_b.push_back((i % 3 == 0) ? 16'(16 + i) : 16'd0);
    check_bias("t2");
    exp_q.push_back(9'h016); exp_q.push_back(9'h022); exp_q.push_back(9'h12E);
    check_results("t2");
    check("t2_err", {err_gap, err_ovf}, 0);

    // Backpressure: four credits, then stall until the consumer drains.
    clear_logs();
    res_ready = 1'b0;
    do_cfg(3'd0, 3'd5, 16'd8);
    for (int i = 0; i < 4; i++) send_beat(8'(3 * i), 16'(i + 1));
    op_valid = 1'b1; op_in = {9{8'd12}}; op_bias = 16'd5;
    repeat (10) @(negedge clk);
    check("t3_stall", op_ready, 0);
    check("t3_beats", bias_log.size(), 4);
    check("t3_held", {res_valid, 8'(rx.size())}, {1'b1, 8'd0});
    @(posedge clk); #1;
    res_ready = 1'b1;
    for (int i = 4; i < 8; i++) send_beat(8'(3 * i), 16'(i + 1));
    wait_done(1);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'(4 * i + 1)});
    check_results("t3");

    // Gap of two cycles after beat 0 of a two-beat pixel.
    clear_logs();
    do_cfg(3'd1, 3'd1, 16'd2);
    send_beat(8'd1, 16'd7);
    @(negedge clk); check("t4_pe_en", pe_en, 1);
    @(negedge clk); check("t4_gap", {err_gap, pe_en, pe_bias}, {1'b1, 1'b0, 16'd7});
    @(posedge clk); #1;
    send_beat(8'd2, 16'd7);
    send_beat(8'd3, 16'd9);
    send_beat(8'd4, 16'd9);
    wait_done(1);
    exp_b.push_back(16'd7); exp_b.push_back(16'd0); exp_b.push_back(16'd9); exp_b.push_back(16'd0);
    check_bias("t4");
    exp_q.push_back(9'h00A); exp_q.push_back(9'h110);
    check_results("t4");
    check("t4_gap_sticky", err_gap, 1);

    // Empty job, then a spurious PE strobe while idle.
    clear_logs();
    do_cfg(3'd0, 3'd0, 16'd0);
    @(negedge clk); check("t5_done", {done, busy, cfg_ready}, 3'b101);
    check("t5_gap_clr", err_gap, 0);
    @(negedge clk); check("t5_done_off", done, 0);
    @(posedge clk); #1; inj = 1'b1;
    @(posedge clk); #1; inj = 1'b0;
    @(negedge clk); check("t5_ovf", {err_ovf, res_valid}, 2'b10);
    repeat (3) @(negedge clk);
    check("t5_quiet", {8'(bias_log.size()), 8'(done_cnt), res_valid}, {8'd0, 8'd1, 1'b0});

    // Reset with two pixels in flight, then a clean job.
    clear_logs();
    do_cfg(3'd0, 3'd2, 16'd4);
    check("t6_ovf_clr", err_ovf, 0);
    send_beat(8'd1, 16'd1);
    send_beat(8'd2, 16'd2);
    #1 reset = 1'b0;
    op_valid = 1'b0;
    #1;
    check("t6_rst_ctl", {cfg_ready, op_ready, pe_en, res_valid, res_last, busy, done, err_gap, err_ovf}, 0);
    check("t6_rst_data", {|pe_in, |pe_weight, pe_bias, pe_step, pe_bound, res_data}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_logs();
    do_cfg(3'd0, 3'd2, 16'd2);
    send_beat(8'd20, 16'd1);
    send_beat(8'd30, 16'd2);
    wait_done(1);
    exp_q.push_back(9'h015); exp_q.push_back(9'h120);
    check_results("t6");
    check("t6_err", {err_gap, err_ovf, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
